// File: rtl/rs_station.sv
// Reservation station for ALU and branch ops.
// Holds issued ops until both operands are known, snoops the ALU and LSB
// result buses, reports free/ready slots to issue and registers one ready
// entry into the ALU input on dispatch.
// Optional build macro RS_OLDEST_FIRST_EN: the ready slot offered to issue
// is the one whose ROB position is closest to rob_head. Without it the
// lowest-index ready slot is offered and rob_head is ignored.
module rs_station #(
   parameter int RS_SIZE = 16,
   parameter int RS_W    = 4,
   parameter int ROB_W   = 4,
   parameter int OP_W    = 6,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              push,
   input  logic [RS_W-1:0]   push_pos,
   input  logic [OP_W-1:0]   push_op,
   input  logic [DATA_W-1:0] push_imm,
   input  logic [DATA_W-1:0] push_pc,
   input  logic [DATA_W-1:0] push_pred_pc,
   input  logic [ROB_W-1:0]  push_robpos,
   input  logic [DATA_W-1:0] push_vj,
   input  logic [DATA_W-1:0] push_vk,
   input  logic              push_qj,
   input  logic              push_qk,
   input  logic              alu_cdb_valid,
   input  logic [ROB_W-1:0]  alu_cdb_robpos,
   input  logic [DATA_W-1:0] alu_cdb_val,
   input  logic              lsb_cdb_valid,
   input  logic [ROB_W-1:0]  lsb_cdb_robpos,
   input  logic [DATA_W-1:0] lsb_cdb_val,
   input  logic [ROB_W-1:0]  rob_head,
   output logic              rs_avail,
   output logic [RS_W-1:0]   rs_avail_pos,
   output logic              rs_ready,
   output logic [RS_W-1:0]   rs_ready_pos,
   input  logic              front,
   input  logic [RS_W-1:0]   front_pos,
   output logic              exec_valid,
   output logic [OP_W-1:0]   exec_op,
   output logic [DATA_W-1:0] exec_v1,
   output logic [DATA_W-1:0] exec_v2,
   output logic [DATA_W-1:0] exec_imm,
   output logic [DATA_W-1:0] exec_pc,
   output logic [DATA_W-1:0] exec_pred_pc,
   output logic [ROB_W-1:0]  exec_robpos
);

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] pred_pc;
      logic [ROB_W-1:0]  robpos;
      logic [DATA_W-1:0] vj;
      logic              qj;
      logic [DATA_W-1:0] vk;
      logic              qk;
   } entry_t;

   logic [RS_SIZE-1:0] busy_q, busy_d;
   entry_t             ent_q [RS_SIZE];
   entry_t             ent_d [RS_SIZE];
   logic [RS_SIZE-1:0] ready_vec;
   logic               dispatch_ok;

   // Resolve a pending operand against this cycle's broadcasts; ALU wins a tie.
   function automatic logic [DATA_W:0] resolve(input logic q, input logic [DATA_W-1:0] v);
      logic [DATA_W:0] r;
      r = {q, v};
      if (q) begin
         if (alu_cdb_valid && v[ROB_W-1:0] == alu_cdb_robpos)
            r = {1'b0, alu_cdb_val};
         else if (lsb_cdb_valid && v[ROB_W-1:0] == lsb_cdb_robpos)
            r = {1'b0, lsb_cdb_val};
      end
      return r;
   endfunction

   assign dispatch_ok = front && busy_q[front_pos] &&
                        !ent_q[front_pos].qj && !ent_q[front_pos].qk;

   // Next-state of the entry array: snoop, push with bypass, dispatch release.
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < RS_SIZE; i++) ent_d[i] = ent_q[i];
      if (clear) begin
         busy_d = '0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i]) begin
               {ent_d[i].qj, ent_d[i].vj} = resolve(ent_q[i].qj, ent_q[i].vj);
               {ent_d[i].qk, ent_d[i].vk} = resolve(ent_q[i].qk, ent_q[i].vk);
            end
         end
         if (push && !busy_q[push_pos]) begin
            busy_d[push_pos]           = 1'b1;
            ent_d[push_pos].op         = push_op;
            ent_d[push_pos].imm        = push_imm;
            ent_d[push_pos].pc         = push_pc;
            ent_d[push_pos].pred_pc    = push_pred_pc;
            ent_d[push_pos].robpos     = push_robpos;
            {ent_d[push_pos].qj, ent_d[push_pos].vj} = resolve(push_qj, push_vj);
            {ent_d[push_pos].qk, ent_d[push_pos].vk} = resolve(push_qk, push_vk);
         end
         if (dispatch_ok) busy_d[front_pos] = 1'b0;
      end
   end

   // Entry storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      end else begin
         busy_q <= busy_d;
         for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
      end
   end

   // Registered ALU issue port; fields hold between dispatches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exec_valid   <= 1'b0;
         exec_op      <= '0;
         exec_v1      <= '0;
         exec_v2      <= '0;
         exec_imm     <= '0;
         exec_pc      <= '0;
         exec_pred_pc <= '0;
         exec_robpos  <= '0;
      end else if (clear) begin
         exec_valid <= 1'b0;
      end else begin
         exec_valid <= dispatch_ok;
         if (dispatch_ok) begin
            exec_op      <= ent_q[front_pos].op;
            exec_v1      <= ent_q[front_pos].vj;
            exec_v2      <= ent_q[front_pos].vk;
            exec_imm     <= ent_q[front_pos].imm;
            exec_pc      <= ent_q[front_pos].pc;
            exec_pred_pc <= ent_q[front_pos].pred_pc;
            exec_robpos  <= ent_q[front_pos].robpos;
         end
      end
   end

   // Lowest-index free slot.
   always_comb begin
      rs_avail     = 1'b0;
      rs_avail_pos = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            rs_avail     = 1'b1;
            rs_avail_pos = RS_W'(i);
         end
      end
   end

   // Ready flags come from registered state only.
   always_comb begin
      for (int i = 0; i < RS_SIZE; i++)
         ready_vec[i] = busy_q[i] && !ent_q[i].qj && !ent_q[i].qk;
   end

`ifdef RS_OLDEST_FIRST_EN
   logic [ROB_W-1:0] age;
   logic [ROB_W-1:0] best_age;

   // Oldest ready entry by ROB distance from head; robpos values are distinct.
   always_comb begin
      rs_ready     = 1'b0;
      rs_ready_pos = '0;
      age          = '0;
      best_age     = '1;
      for (int i = 0; i < RS_SIZE; i++) begin
         age = ent_q[i].robpos - rob_head;
         if (ready_vec[i] && (!rs_ready || age < best_age)) begin
            rs_ready     = 1'b1;
            rs_ready_pos = RS_W'(i);
            best_age     = age;
         end
      end
   end
`else
   logic rob_head_unused;
   assign rob_head_unused = ^rob_head;

   // Lowest-index ready entry.
   always_comb begin
      rs_ready     = 1'b0;
      rs_ready_pos = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (ready_vec[i]) begin
            rs_ready     = 1'b1;
            rs_ready_pos = RS_W'(i);
         end
      end
   end
`endif

endmodule
